// File: rtl/datapath_controller_if.sv
// Bus between the datapath controller, instruction memory and the datapath.
// The controller is the master: it drives every control line and receives IR_data.
interface datapath_controller_if #(
  parameter int PC_W = 7
);
  logic [15:0]     IR_data;
  logic [PC_W-1:0] PC_addr;
  logic [7:0]      D_Addr;
  logic            D_Wr;
  logic            RF_s;
  logic [3:0]      RF_W_Addr;
  logic            RF_W_en;
  logic [3:0]      RF_Ra_Addr;
  logic [3:0]      RF_Rb_Addr;
  logic [2:0]      ALU_s0;
  logic [15:0]     IR_out;
  logic [3:0]      State;
  logic            Halted;

  modport master (
    input  IR_data,
    output PC_addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, IR_out, State, Halted
  );

  modport slave (
    output IR_data,
    input  PC_addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, IR_out, State, Halted
  );
endinterface

// File: rtl/datapath_controller.sv
// Fetch/decode/execute control FSM for the register-file/ALU datapath.
// Optional macro JMP_EN adds the JUMP instruction (opcode 0110); without it 0110 is illegal.
module datapath_controller #(
  parameter int PC_W            = 7,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  datapath_controller_if.master bus
);

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
`ifdef JMP_EN
    , ST_JUMP = 4'd10
`endif
  } state_t;

  typedef struct packed {
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_en;
    logic [3:0] rf_ra_addr;
    logic [3:0] rf_rb_addr;
    logic [2:0] alu_s0;
    logic       halted;
  } ctrl_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_nxt_s;
  logic [15:0]     ir_r;
  logic [15:0]     ir_nxt_s;
  ctrl_t           ctrl_r;

  // Controls are a pure function of (state, IR); evaluating it on the next
  // state lets the outputs be flops that still match the current state.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [15:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      ST_STORE: begin
        c.rf_ra_addr = ir[11:8];
        c.d_addr     = ir[7:0];
        c.d_wr       = 1'b1;
      end
      ST_LOAD_A: begin
        c.d_addr = ir[11:4];
      end
      ST_LOAD_B: begin
        c.d_addr    = ir[11:4];
        c.rf_s      = 1'b1;
        c.rf_w_addr = ir[3:0];
        c.rf_w_en   = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        c.rf_ra_addr = ir[11:8];
        c.rf_rb_addr = ir[7:4];
        c.rf_w_addr  = ir[3:0];
        c.rf_w_en    = 1'b1;
        c.alu_s0     = (st == ST_ADD) ? 3'd1 : 3'd2;
      end
      ST_HALT: begin
        c.halted = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Next-state, next-PC and next-IR selection.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    case (state_r)
      ST_INIT: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        ir_nxt_s    = bus.IR_data;
        pc_nxt_s    = pc_r + PC_W'(1'b1);
        state_nxt_s = ST_DECODE;
      end
      ST_DECODE: begin
        case (ir_r[15:12])
          4'h0:    state_nxt_s = ST_NOOP;
          4'h1:    state_nxt_s = ST_STORE;
          4'h2:    state_nxt_s = ST_LOAD_A;
          4'h3:    state_nxt_s = ST_ADD;
          4'h4:    state_nxt_s = ST_SUB;
          4'h5:    state_nxt_s = ST_HALT;
`ifdef JMP_EN
          4'h6:    state_nxt_s = ST_JUMP;
`endif
          default: begin
            if (HALT_ON_ILLEGAL != 0) begin
              state_nxt_s = ST_HALT;
            end else begin
              state_nxt_s = ST_NOOP;
            end
          end
        endcase
      end
      ST_LOAD_A: begin
        state_nxt_s = ST_LOAD_B;
      end
      ST_NOOP, ST_STORE, ST_ADD, ST_SUB, ST_LOAD_B: begin
        state_nxt_s = ST_FETCH;
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
`ifdef JMP_EN
      ST_JUMP: begin
        pc_nxt_s    = ir_r[PC_W-1:0];
        state_nxt_s = ST_FETCH;
      end
`endif
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // State, PC, IR and registered control outputs; reset clears all at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_INIT;
      pc_r    <= '0;
      ir_r    <= 16'h0000;
      ctrl_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      ir_r    <= ir_nxt_s;
      ctrl_r  <= decode_ctrl(state_nxt_s, ir_nxt_s);
    end
  end

  assign bus.PC_addr    = pc_r;
  assign bus.IR_out     = ir_r;
  assign bus.State      = state_r;
  assign bus.D_Addr     = ctrl_r.d_addr;
  assign bus.D_Wr       = ctrl_r.d_wr;
  assign bus.RF_s       = ctrl_r.rf_s;
  assign bus.RF_W_Addr  = ctrl_r.rf_w_addr;
  assign bus.RF_W_en    = ctrl_r.rf_w_en;
  assign bus.RF_Ra_Addr = ctrl_r.rf_ra_addr;
  assign bus.RF_Rb_Addr = ctrl_r.rf_rb_addr;
  assign bus.ALU_s0     = ctrl_r.alu_s0;
  assign bus.Halted     = ctrl_r.halted;

endmodule
